// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: multi-channel pulse/PWM generator.
//   One shared free-running period counter, 0..T. T is the active terminal, and each period
//   lasts T+1 cycles. Each channel drives a registered pulse while CNT lies inside its
//   [LO,HI] window. A channel runs either continuously or as a one-shot.
//   Period and channel config are double-buffered. New values are written to a staged copy,
//   and the active copy is loaded only at a wrap, so a period never sees a config change.
//
// Ports (pulse_gen_multi):
//   clk_i       clock, all logic on posedge
//   rst_i       asynchronous active-high reset
//   en_i        1 = run; 0 = counter cleared, pulses low
//   period_i    next terminal value, sampled at wrap
//   cfg_we_i    write staged cfg of channel cfg_ch_i (out-of-range index ignored)
//   cfg_ch_i    channel index
//   cfg_lo_i    window start (inclusive)
//   cfg_hi_i    window end (inclusive)
//   cfg_mode_i  0 = continuous, 1 = one-shot
//   trig_i      arm all idle one-shot channels
//   cnt_o       current counter value
//   wrap_o      1-cycle strobe, high the cycle after CNT==T
//   pulse_o     registered channel outputs

// pulse_gen_ch: one channel. Holds the staged and active cfg, the one-shot FSM and the
// pulse register.
//   live_i  counter was running last cycle, so cnt_i is a real period position
//   load_i  period boundary: the wrap, or the first cycle after EN rises
module pulse_gen_ch #(
    parameter int CNT_W = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             live_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] lo_i,
    input  logic [CNT_W-1:0] hi_i,
    input  logic             mode_i,
    input  logic             trig_i,
    output logic             pulse_o
);
    typedef struct packed {
        logic [CNT_W-1:0] lo;
        logic [CNT_W-1:0] hi;
        logic             mode;
    } cfg_t;

    typedef enum logic [1:0] {IDLE, ARMED, FIRING} os_state_t;

    cfg_t      stg_q, act_q;
    os_state_t state_q, state_d;
    logic      pulse_q, pulse_d;
    logic      run;

    // Continuous channels and EN=0 hold the FSM in IDLE. A switch from continuous to
    // one-shot therefore always starts from IDLE.
    always_comb begin
        state_d = state_q;
        if (!en_i || !act_q.mode) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (trig_i) state_d = ARMED;
                ARMED:   if (load_i) state_d = FIRING;
                FIRING:  if (load_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign run     = act_q.mode ? (state_q == FIRING) : 1'b1;
    assign pulse_d = en_i && live_i && run && (act_q.lo <= cnt_i) && (cnt_i <= act_q.hi);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stg_q   <= '0;
            act_q   <= '0;
            state_q <= IDLE;
            pulse_q <= 1'b0;
        end else begin
            // The active copy takes the pre-edge staged value. A write in the same cycle
            // lands in staged and waits for the next boundary.
            if (load_i) act_q <= stg_q;
            if (we_i)   stg_q <= '{lo: lo_i, hi: hi_i, mode: mode_i};
            state_q <= state_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;
endmodule

module pulse_gen_multi #(
    parameter int CNT_W      = 11,
    parameter int NUM_CH     = 2,
    parameter int DEF_PERIOD = 800,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [CNT_W-1:0]  period_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_lo_i,
    input  logic [CNT_W-1:0]  cfg_hi_i,
    input  logic              cfg_mode_i,
    input  logic              trig_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              wrap_o,
    output logic [NUM_CH-1:0] pulse_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d, term_q;
    logic             live_q, wrap_q;
    logic             load;

    // live_q resets to 1 so that the first period after reset runs with DEF_PERIOD and
    // the reset cfg. A later rising EN finds live_q=0 and takes a load cycle first.
    assign load = en_i && (!live_q || (cnt_q == term_q));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!en_i || load) cnt_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            term_q <= CNT_W'(DEF_PERIOD);
            live_q <= 1'b1;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            if (load) term_q <= period_i;
            live_q <= en_i;
            // The startup load after a rising EN does not end a period, so it raises no strobe.
            wrap_q <= load && live_q;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulse_gen_ch #(.CNT_W(CNT_W)) u_ch (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (en_i),
            .live_i  (live_q),
            .load_i  (load),
            .cnt_i   (cnt_q),
            .we_i    (cfg_we_i && (cfg_ch_i == CH_W'(i))),
            .lo_i    (cfg_lo_i),
            .hi_i    (cfg_hi_i),
            .mode_i  (cfg_mode_i),
            .trig_i  (trig_i),
            .pulse_o (pulse_o[i])
        );
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = wrap_q;
endmodule

// File: tb/tb_pulse_gen_multi.sv
module tb_pulse_gen_multi;
    localparam int CW = 11, NCH = 2, DEFP = 800;

    logic           clk = 1'b0, rst = 1'b1, en = 1'b1, we = 1'b0, md = 1'b0, trig = 1'b0;
    logic [CW-1:0]  per = 11'd800, lo = '0, hi = '0;
    logic           ch = 1'b0;
    logic [CW-1:0]  cnt;
    logic           wrap;
    logic [NCH-1:0] pulse;

    always #5 clk = ~clk;

    pulse_gen_multi #(.CNT_W(CW), .NUM_CH(NCH), .DEF_PERIOD(DEFP)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .period_i(per), .cfg_we_i(we), .cfg_ch_i(ch),
        .cfg_lo_i(lo), .cfg_hi_i(hi), .cfg_mode_i(md), .trig_i(trig),
        .cnt_o(cnt), .wrap_o(wrap), .pulse_o(pulse));

    int checks = 0, failures = 0;

    typedef struct {
        logic [CW-1:0]  cnt;
        logic           wrap;
        logic [NCH-1:0] pulse;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int per; int lo; int hi; int len; int hcnt;
    } vec_t;
    vec_t vt[7];

    // Reference model state, written from the behavioural description.
    logic [CW-1:0] m_cnt, m_T;
    bit            m_live;
    logic [CW-1:0] s_lo[NCH], s_hi[NCH], a_lo[NCH], a_hi[NCH];
    bit            s_md[NCH], a_md[NCH];
    int            os[NCH];   // 0 idle, 1 armed, 2 firing

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic model_reset();
        m_cnt = '0; m_T = CW'(DEFP); m_live = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            s_lo[c] = '0; s_hi[c] = '0; a_lo[c] = '0; a_hi[c] = '0;
            s_md[c] = 0; a_md[c] = 0; os[c] = 0;
        end
        sb.delete();
    endtask

    // Advance the model by one edge using the current inputs, and queue the outputs the
    // DUT must show after that edge.
    task automatic model_step();
        exp_t e;
        bit ld, run;
        ld = en && (!m_live || m_cnt == m_T);
        for (int c = 0; c < NCH; c++) begin
            run = a_md[c] ? (os[c] == 2) : 1'b1;
            e.pulse[c] = en && m_live && run && (a_lo[c] <= m_cnt) && (m_cnt <= a_hi[c]);
            if (!en || !a_md[c])       os[c] = 0;
            else if (os[c] == 0 && trig) os[c] = 1;
            else if (os[c] == 1 && ld)   os[c] = 2;
            else if (os[c] == 2 && ld)   os[c] = 0;
        end
        e.wrap = ld && m_live;
        e.cnt  = (!en || ld) ? '0 : m_cnt + 1'b1;
        if (ld) begin
            m_T = per;
            for (int c = 0; c < NCH; c++) begin
                a_lo[c] = s_lo[c]; a_hi[c] = s_hi[c]; a_md[c] = s_md[c];
            end
        end
        if (we) begin
            s_lo[ch] = lo; s_hi[ch] = hi; s_md[ch] = md;
        end
        m_cnt  = e.cnt;
        m_live = en;
        sb.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (cnt !== e.cnt || wrap !== e.wrap || pulse !== e.pulse) begin
            failures++;
            $display("FAIL sb t=%0t cnt=%0d want %0d wrap=%0b want %0b pulse=%b want %b",
                     $time, cnt, e.cnt, wrap, e.wrap, pulse, e.pulse);
        end
    endtask

    task automatic wr(input int c, input int l, input int h, input bit m);
        ch = c[0]; lo = CW'(l); hi = CW'(h); md = m; we = 1'b1;
        cyc();
        we = 1'b0;
    endtask

    // Run until the next wrap strobe. Returns the period length and the high-cycle counts.
    // trig_at / we_at pulse TRIG / CFG_WE on that iteration (iteration n drives the edge
    // that leaves CNT==n).
    task automatic measure(input int trig_at, input int we_at,
                           output int len, output int h0, output int h1);
        len = 0; h0 = 0; h1 = 0;
        for (int n = 0; n < 2000; n++) begin
            trig = (n == trig_at);
            we   = (n == we_at);
            cyc();
            trig = 1'b0; we = 1'b0;
            len++;
            h0 += int'(pulse[0]);
            h1 += int'(pulse[1]);
            if (wrap) return;
        end
        expired("measure");
    endtask

    task automatic run_to(input int v);
        for (int n = 0; n < 2000; n++) begin
            if (cnt == CW'(v)) return;
            cyc();
        end
        expired($sformatf("run_to_%0d", v));
    endtask

    int len, h0, h1;
    int os_trig[7], os_exp[7];

    initial begin
        vt[0] = '{per: 800, lo: 501, hi: 800,  len: 801, hcnt: 300};
        vt[1] = '{per: 99,  lo: 10,  hi: 19,   len: 100, hcnt: 10};
        vt[2] = '{per: 99,  lo: 7,   hi: 3,    len: 100, hcnt: 0};
        vt[3] = '{per: 99,  lo: 0,   hi: 99,   len: 100, hcnt: 100};
        vt[4] = '{per: 49,  lo: 0,   hi: 0,    len: 50,  hcnt: 1};
        vt[5] = '{per: 49,  lo: 40,  hi: 200,  len: 50,  hcnt: 10};
        vt[6] = '{per: 20,  lo: 0,   hi: 2047, len: 21,  hcnt: 21};
        os_trig = '{3, 2, -1, 29, -1, -1, -1};
        os_exp  = '{0, 5, 0, 0, 0, 5, 0};

        // Reset state.
        #2;
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_pulse", int'(pulse), 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // First period: DEF_PERIOD with the reset cfg gives a 1-cycle pulse at CNT=0.
        measure(-1, -1, len, h0, h1);
        chk("def_len", len, DEFP + 1);
        chk("def_h0", h0, 1);
        chk("def_h1", h1, 1);

        // Table of windows and periods on ch0, continuous mode.
        for (int i = 0; i < 7; i++) begin
            per = CW'(vt[i].per);
            wr(0, vt[i].lo, vt[i].hi, 1'b0);
            measure(-1, -1, len, h0, h1);
            measure(-1, -1, len, h0, h1);
            chk($sformatf("vec%0d_len", i), len, vt[i].len);
            chk($sformatf("vec%0d_high", i), h0, vt[i].hcnt);
        end

        // A ch1 write on the wrap cycle takes effect one period later.
        per = 11'd99;
        measure(-1, -1, len, h0, h1);
        ch = 1'b1; lo = 11'd10; hi = 11'd19; md = 1'b0;
        measure(-1, 99, len, h0, h1);
        chk("wrwrap_p0_h1", h1, 1);
        measure(-1, -1, len, h0, h1);
        chk("wrwrap_p1_h1", h1, 1);
        measure(-1, -1, len, h0, h1);
        chk("wrwrap_p2_h1", h1, 10);

        // One-shot on ch0. The TRIG during FIRING is ignored. A TRIG on the wrap cycle
        // fires in the period after next.
        per = 11'd29;
        wr(0, 0, 4, 1'b1);
        measure(-1, -1, len, h0, h1);
        measure(-1, -1, len, h0, h1);
        for (int i = 0; i < 7; i++) begin
            measure(os_trig[i], -1, len, h0, h1);
            chk($sformatf("oneshot_p%0d", i), h0, os_exp[i]);
        end

        // PERIOD=0 gives a wrap on every cycle.
        per = '0;
        measure(-1, -1, len, h0, h1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("per0_wrap%0d", i), int'(wrap), 1);
        end
        per = 11'd800;
        cyc();

        // Async reset mid-period while a pulse is high.
        wr(0, 300, 800, 1'b0);
        measure(-1, -1, len, h0, h1);
        run_to(400);
        chk("pre_rst_pulse", int'(pulse[0]), 1);
        per = 11'd50;
        rst = 1'b1;
        #1;
        chk("mid_rst_cnt", int'(cnt), 0);
        chk("mid_rst_wrap", int'(wrap), 0);
        chk("mid_rst_pulse", int'(pulse), 0);
        model_reset();
        #2;
        rst = 1'b0;
        measure(-1, -1, len, h0, h1);
        chk("post_rst_len", len, DEFP + 1);
        chk("post_rst_h0", h0, 1);

        // Drop EN for 5 cycles at CNT=300, stage a new cfg, then re-enable.
        per = 11'd400;
        measure(-1, -1, len, h0, h1);
        run_to(300);
        en = 1'b0;
        wr(0, 0, 2, 1'b0);
        per = 11'd60;
        for (int i = 0; i < 4; i++) cyc();
        chk("en0_cnt", int'(cnt), 0);
        chk("en0_pulse", int'(pulse), 0);
        en = 1'b1;
        measure(-1, -1, len, h0, h1);
        chk("reen_len", len, 62);
        chk("reen_h0", h0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
